// File: rtl/el2_lsu_trigger_cnt_pkg.sv
// rtl/el2_lsu_trigger_cnt_pkg.sv - shared types for the LSU debug trigger unit
package el2_lsu_trigger_cnt_pkg;

   // Storage widths of the per-trigger config record; AW and CW of the
   // trigger unit must not exceed these.
   localparam int TRIG_AW_MAX = 64;
   localparam int TRIG_CW_MAX = 32;

   typedef enum logic [1:0] {
      EXACT = 2'd0,
      NAPOT = 2'd1,
      GE    = 2'd2,
      LT    = 2'd3
   } el2_trig_mode_e;

   // One trigger's configuration; tdata2/thresh are zero-extended into the
   // wide fields.
   typedef struct packed {
      logic                   select;
      el2_trig_mode_e         mode;
      logic                   store;
      logic                   load;
      logic                   m;
      logic                   chain;
      logic                   cnt_en;
      logic [TRIG_AW_MAX-1:0] tdata2;
      logic [TRIG_CW_MAX-1:0] thresh;
   } el2_trig_cfg_t;

endpackage

// File: rtl/el2_lsu_trigger_cnt_if.sv
// rtl/el2_lsu_trigger_cnt_if.sv - LSU M-stage access and trigger result bundle
interface el2_lsu_trigger_cnt_if #(
   parameter int NUM_TRIG = 4,
   parameter int AW       = 32
);
   logic                lsu_valid_m;
   logic                lsu_load_m;
   logic                lsu_store_m;
   logic                lsu_dma_m;
   logic [1:0]          lsu_size_m;
   logic [AW-1:0]       lsu_addr_m;
   logic [AW-1:0]       store_data_m;
   logic                flush_m;
   logic [NUM_TRIG-1:0] lsu_trigger_match_m;
   logic [NUM_TRIG-1:0] lsu_trigger_hit_r;

   // LSU side: presents the access, receives trigger results
   modport master (
      output lsu_valid_m, lsu_load_m, lsu_store_m, lsu_dma_m, lsu_size_m,
             lsu_addr_m, store_data_m, flush_m,
      input  lsu_trigger_match_m, lsu_trigger_hit_r
   );

   // Trigger unit side
   modport slave (
      input  lsu_valid_m, lsu_load_m, lsu_store_m, lsu_dma_m, lsu_size_m,
             lsu_addr_m, store_data_m, flush_m,
      output lsu_trigger_match_m, lsu_trigger_hit_r
   );
endinterface

// File: rtl/el2_lsu_trig_cmp.sv
// rtl/el2_lsu_trig_cmp.sv - operand selection and four-mode trigger comparator
module el2_lsu_trig_cmp
   import el2_lsu_trigger_cnt_pkg::*;
#(
   parameter int AW = 32
) (
   input  el2_trig_cfg_t  cfg,
   input  logic [1:0]     lsu_size_m,
   input  logic [AW-1:0]  lsu_addr_m,
   input  logic [AW-1:0]  store_data_m,
   output logic           cmp_hit
);

   logic [AW-1:0] tdata2;
   logic [AW-1:0] operand;
   logic [AW-1:0] napot_care;
   logic          unused_cfg;

   assign tdata2     = cfg.tdata2[AW-1:0];
   // Fields used elsewhere (counter, chain) pass through this port untouched
   assign unused_cfg = ^cfg;

   // Operand: address, or store data zero-extended from the access size
   always_comb begin
      operand = lsu_addr_m;
      if (cfg.select) begin
         case (lsu_size_m)
            2'd0:    operand = AW'(store_data_m[7:0]);
            2'd1:    operand = AW'(store_data_m[15:0]);
            default: operand = store_data_m;
         endcase
      end
   end

   // tdata2 ^ (tdata2+1) sets every bit up to and including the lowest zero;
   // those bits are don't-care. All-ones tdata2 leaves nothing to compare.
   assign napot_care = ~(tdata2 ^ (tdata2 + AW'(1)));

   // Compare against tdata2 in the configured mode
   always_comb begin
      cmp_hit = 1'b0;
      case (cfg.mode)
         EXACT:   cmp_hit = (operand == tdata2);
         NAPOT:   cmp_hit = (((operand ^ tdata2) & napot_care) == '0);
         GE:      cmp_hit = (operand >= tdata2);
         LT:      cmp_hit = (operand <  tdata2);
         default: cmp_hit = 1'b0;
      endcase
   end

endmodule

// File: rtl/el2_lsu_trigger_cnt.sv
// rtl/el2_lsu_trigger_cnt.sv - LSU debug triggers with chaining and hit counters
module el2_lsu_trigger_cnt
   import el2_lsu_trigger_cnt_pkg::*;
#(
   parameter int NUM_TRIG = 4,
   parameter int AW       = 32,
   parameter int CW       = 8
) (
   input  logic                   clk,
   input  logic                   rst_l,
   input  logic [NUM_TRIG-1:0]    trig_select,
   input  logic [2*NUM_TRIG-1:0]  trig_mode,
   input  logic [NUM_TRIG-1:0]    trig_store,
   input  logic [NUM_TRIG-1:0]    trig_load,
   input  logic [NUM_TRIG-1:0]    trig_m,
   input  logic [NUM_TRIG-1:0]    trig_chain,
   input  logic [NUM_TRIG-1:0]    trig_cnt_en,
   input  logic [AW*NUM_TRIG-1:0] trig_tdata2,
   input  logic [CW*NUM_TRIG-1:0] trig_thresh,
   input  logic [NUM_TRIG-1:0]    trig_cnt_clr,
   el2_lsu_trigger_cnt_if.slave   lsu,
   output logic [CW*NUM_TRIG-1:0] trig_count
);

   el2_trig_cfg_t       cfg [NUM_TRIG];
   logic [NUM_TRIG-1:0] cmp_hit;
   logic [NUM_TRIG-1:0] raw;
   logic [NUM_TRIG-1:0] qual;
   logic [NUM_TRIG-1:0] fire;
   logic [NUM_TRIG-1:0] hit_r;

   // Unpack the flat CSR-side ports into one record per trigger
   always_comb begin
      for (int i = 0; i < NUM_TRIG; i++) begin
         cfg[i]        = '0;
         cfg[i].select = trig_select[i];
         cfg[i].mode   = el2_trig_mode_e'(trig_mode[2*i +: 2]);
         cfg[i].store  = trig_store[i];
         cfg[i].load   = trig_load[i];
         cfg[i].m      = trig_m[i];
         cfg[i].chain  = trig_chain[i];
         cfg[i].cnt_en = trig_cnt_en[i];
         cfg[i].tdata2 = TRIG_AW_MAX'(trig_tdata2[AW*i +: AW]);
         cfg[i].thresh = TRIG_CW_MAX'(trig_thresh[CW*i +: CW]);
      end
   end

   for (genvar g = 0; g < NUM_TRIG; g++) begin : g_trig
      logic [CW-1:0]          cnt_q;
      logic [CW-1:0]          cnt_d;
      logic [CW-1:0]          cnt_inc;
      logic [TRIG_CW_MAX-1:0] thr;
      logic                   accept;
      logic                   fire_g;

      el2_lsu_trig_cmp #(.AW(AW)) u_cmp (
         .cfg          (cfg[g]),
         .lsu_size_m   (lsu.lsu_size_m),
         .lsu_addr_m   (lsu.lsu_addr_m),
         .store_data_m (lsu.store_data_m),
         .cmp_hit      (cmp_hit[g])
      );

      // Data triggers are never armed by loads; DMA traffic is invisible
      assign raw[g] = cfg[g].m & lsu.lsu_valid_m & ~lsu.lsu_dma_m & cmp_hit[g] &
                      ((cfg[g].store & lsu.lsu_store_m) |
                       (cfg[g].load & lsu.lsu_load_m & ~cfg[g].select));

      assign accept  = qual[g] & ~lsu.flush_m;
      assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
      assign thr     = (cfg[g].thresh == '0) ? TRIG_CW_MAX'(1) : cfg[g].thresh;

      // Counter next state and fire decision; a CSR clear beats a match
      always_comb begin
         cnt_d  = cnt_q;
         fire_g = 1'b0;
         if (trig_cnt_clr[g]) begin
            cnt_d = '0;
         end else if (cfg[g].cnt_en) begin
            if (accept) begin
               if (TRIG_CW_MAX'(cnt_inc) >= thr) begin
                  fire_g = 1'b1;
                  cnt_d  = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end else begin
            fire_g = accept;
         end
      end

      // Hit counter state
      always_ff @(posedge clk) begin
         if (!rst_l) cnt_q <= '0;
         else        cnt_q <= cnt_d;
      end

      assign fire[g]                = fire_g;
      assign trig_count[CW*g +: CW] = cnt_q;
   end

   // Pair chaining: an even trigger with chain set ANDs itself with its odd partner
   always_comb begin
      qual = raw;
      for (int i = 0; i < NUM_TRIG; i += 2) begin
         if (cfg[i].chain) begin
            qual[i]   = raw[i] & raw[i+1];
            qual[i+1] = raw[i] & raw[i+1];
         end
      end
   end

   // R-stage register for the fire pulses
   always_ff @(posedge clk) begin
      if (!rst_l) hit_r <= '0;
      else        hit_r <= fire;
   end

   assign lsu.lsu_trigger_match_m = qual;
   assign lsu.lsu_trigger_hit_r   = hit_r;

endmodule

// File: tb/tb_el2_lsu_trigger_cnt.sv
// tb/tb_el2_lsu_trigger_cnt.sv - scoreboard bench for el2_lsu_trigger_cnt
module tb_el2_lsu_trigger_cnt;
   localparam int N  = 4;
   localparam int AW = 32;
   localparam int CW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_l;
   logic [N-1:0]     t_select, t_store, t_load, t_m, t_chain, t_cnt_en, t_cnt_clr;
   logic [2*N-1:0]   t_mode;
   logic [AW*N-1:0]  t_tdata2;
   logic [CW*N-1:0]  t_thresh;
   logic [CW*N-1:0]  trig_count;

   el2_lsu_trigger_cnt_if #(.NUM_TRIG(N), .AW(AW)) bus ();

   el2_lsu_trigger_cnt #(.NUM_TRIG(N), .AW(AW), .CW(CW)) dut (
      .clk          (clk),
      .rst_l        (rst_l),
      .trig_select  (t_select),
      .trig_mode    (t_mode),
      .trig_store   (t_store),
      .trig_load    (t_load),
      .trig_m       (t_m),
      .trig_chain   (t_chain),
      .trig_cnt_en  (t_cnt_en),
      .trig_tdata2  (t_tdata2),
      .trig_thresh  (t_thresh),
      .trig_cnt_clr (t_cnt_clr),
      .lsu          (bus),
      .trig_count   (trig_count)
   );

   typedef struct {
      int             id;
      logic [N-1:0]   match;
      logic [N-1:0]   hit;
      logic [CW*N-1:0] cnt;
   } exp_t;

   exp_t sbq[$];
   int   tests   = 0;
   int   failed  = 0;
   int   step_id = 0;
   int   mcnt[N];

   // NAPOT: ignore everything up to and including the lowest clear bit
   function automatic bit napot_hit(logic [AW-1:0] op, logic [AW-1:0] td);
      int k;
      if (td == '1) return 1'b1;
      k = 0;
      while (td[k]) k++;
      return (64'(op) >> (k + 1)) == (64'(td) >> (k + 1));
   endfunction

   // Reference model for one access; pushes the expected outcome, then
   // advances to the next drive point
   task automatic step();
      exp_t e;
      bit   raw[N];
      bit   q[N];
      logic [AW-1:0] op, td;
      bit   h, acc;
      int   nx, thr;
      for (int i = 0; i < N; i++) begin
         td = t_tdata2[AW*i +: AW];
         if (!t_select[i])              op = bus.lsu_addr_m;
         else if (bus.lsu_size_m == 0)  op = bus.store_data_m % 256;
         else if (bus.lsu_size_m == 1)  op = bus.store_data_m % 65536;
         else                           op = bus.store_data_m;
         case (t_mode[2*i +: 2])
            2'd0:    h = (op == td);
            2'd1:    h = napot_hit(op, td);
            2'd2:    h = (op >= td);
            default: h = (op < td);
         endcase
         raw[i] = t_m[i] && bus.lsu_valid_m && !bus.lsu_dma_m && h &&
                  ((t_store[i] && bus.lsu_store_m) ||
                   (t_load[i] && bus.lsu_load_m && !t_select[i]));
      end
      q = raw;
      for (int i = 0; i < N; i += 2)
         if (t_chain[i]) begin
            q[i]   = raw[i] && raw[i+1];
            q[i+1] = raw[i] && raw[i+1];
         end
      e.id = step_id;
      step_id++;
      e.hit = '0;
      for (int i = 0; i < N; i++) begin
         e.match[i] = q[i];
         acc = q[i] && !bus.flush_m;
         if (t_cnt_clr[i]) mcnt[i] = 0;
         else if (t_cnt_en[i]) begin
            if (acc) begin
               nx  = (mcnt[i] + 1 > 255) ? 255 : mcnt[i] + 1;
               thr = (t_thresh[CW*i +: CW] == 0) ? 1 : int'(t_thresh[CW*i +: CW]);
               if (nx >= thr) begin
                  e.hit[i] = 1'b1;
                  mcnt[i]  = 0;
               end else mcnt[i] = nx;
            end
         end else e.hit[i] = acc;
         if (!rst_l) begin
            mcnt[i]  = 0;
            e.hit[i] = 1'b0;
         end
      end
      for (int i = 0; i < N; i++) e.cnt[CW*i +: CW] = CW'(mcnt[i]);
      sbq.push_back(e);
      @(negedge clk);
   endtask

   task automatic chk(string name, int id, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
      end
   endtask

   // Monitor: the DUT presents one result set per clock
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("match_m", e.id, 32'(bus.lsu_trigger_match_m), 32'(e.match));
            chk("hit_r",   e.id, 32'(bus.lsu_trigger_hit_r),   32'(e.hit));
            chk("count",   e.id, 32'(trig_count),              32'(e.cnt));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic clear_cfg();
      t_select = '0; t_store = '0; t_load = '0; t_m = '0; t_chain = '0;
      t_cnt_en = '0; t_cnt_clr = '0; t_mode = '0; t_tdata2 = '0; t_thresh = '0;
   endtask

   task automatic set_trig(int i, bit sel, logic [1:0] mode, bit st, bit ld, bit ch,
                           bit ce, logic [AW-1:0] td, logic [CW-1:0] th);
      t_select[i] = sel; t_mode[2*i +: 2] = mode; t_store[i] = st; t_load[i] = ld;
      t_m[i] = 1'b1; t_chain[i] = ch; t_cnt_en[i] = ce;
      t_tdata2[AW*i +: AW] = td; t_thresh[CW*i +: CW] = th;
   endtask

   task automatic access(bit v, bit ld, bit st, bit dma, logic [1:0] sz,
                         logic [AW-1:0] a, logic [AW-1:0] d, bit fl);
      bus.lsu_valid_m = v; bus.lsu_load_m = ld; bus.lsu_store_m = st;
      bus.lsu_dma_m = dma; bus.lsu_size_m = sz; bus.lsu_addr_m = a;
      bus.store_data_m = d; bus.flush_m = fl;
   endtask

   task automatic idle();
      access(0, 0, 0, 0, 2'd2, '0, '0, 0);
   endtask

   initial begin
      logic [AW-1:0] td;
      int            j;
      for (int i = 0; i < N; i++) mcnt[i] = 0;
      clear_cfg();
      idle();
      rst_l = 1'b0;
      step(); step();
      rst_l = 1'b1;

      // exact address
      set_trig(0, 0, 2'd0, 1, 0, 0, 0, 32'h8000_1000, 8'd0);
      access(1, 0, 1, 0, 2'd2, 32'h8000_1000, 32'h0, 0); step();
      access(1, 0, 1, 0, 2'd2, 32'h8000_1004, 32'h0, 0); step();
      idle(); step();

      // NAPOT
      clear_cfg();
      set_trig(0, 0, 2'd1, 0, 1, 0, 0, 32'h8000_10FF, 8'd0);
      access(1, 1, 0, 0, 2'd2, 32'h8000_1080, 32'h0, 0); step();
      access(1, 1, 0, 0, 2'd2, 32'h8000_1100, 32'h0, 0); step();
      set_trig(0, 0, 2'd1, 0, 1, 0, 0, 32'hFFFF_FFFF, 8'd0);
      access(1, 1, 0, 0, 2'd2, 32'h1234_5678, 32'h0, 0); step();

      // range chain
      clear_cfg();
      set_trig(0, 0, 2'd2, 1, 1, 1, 0, 32'h2000, 8'd0);
      set_trig(1, 0, 2'd3, 1, 1, 0, 0, 32'h3000, 8'd0);
      access(1, 0, 1, 0, 2'd2, 32'h2800, 32'h0, 0); step();
      access(1, 0, 1, 0, 2'd2, 32'h3800, 32'h0, 0); step();
      t_chain[0] = 1'b0;
      access(1, 0, 1, 0, 2'd2, 32'h3800, 32'h0, 0); step();

      // store data with size masking
      clear_cfg();
      set_trig(0, 1, 2'd0, 1, 1, 0, 0, 32'hAB, 8'd0);
      access(1, 0, 1, 0, 2'd0, 32'h40, 32'h1234_56AB, 0); step();
      access(1, 1, 0, 0, 2'd0, 32'hAB, 32'h1234_56AB, 0); step();
      access(1, 0, 1, 1, 2'd0, 32'h40, 32'h1234_56AB, 0); step();

      // counter: threshold, clear, zero threshold
      clear_cfg();
      set_trig(0, 0, 2'd0, 1, 0, 0, 1, 32'h100, 8'd3);
      access(1, 0, 1, 0, 2'd2, 32'h100, 32'h0, 0);
      step(); step(); step(); step();
      t_cnt_clr[0] = 1'b1; step(); t_cnt_clr[0] = 1'b0;
      t_thresh[7:0] = 8'd0; step(); step();

      // flush and reset during an access
      t_thresh[7:0] = 8'd3;
      step();
      access(1, 0, 1, 0, 2'd2, 32'h100, 32'h0, 1); step();
      access(1, 0, 1, 0, 2'd2, 32'h100, 32'h0, 0);
      rst_l = 1'b0; step(); rst_l = 1'b1;
      idle(); step();

      // randomized traffic
      for (int r = 0; r < 600; r++) begin
         if (r % 25 == 0) begin
            clear_cfg();
            for (int i = 0; i < N; i++) begin
               td = ($urandom % 4 == 0) ? 32'($urandom) : (32'h1000 | $urandom_range(0, 255));
               if (($urandom % 3) == 0) td = td % 256;
               set_trig(i, ($urandom % 4) == 0, 2'($urandom % 4), 1'($urandom % 2),
                        1'($urandom % 2), ($urandom % 3) == 0, 1'($urandom % 2),
                        td, 8'($urandom % 5));
               if (t_mode[2*i +: 2] == 2'd1)
                  t_tdata2[AW*i +: AW] = td | ((32'd1 << ($urandom % 8)) - 1);
               t_m[i] = ($urandom % 8) != 0;
            end
         end
         j  = $urandom % N;
         td = t_tdata2[AW*j +: AW];
         j  = $urandom % 2;
         access(($urandom % 8) != 0, j == 1, j == 0, ($urandom % 10) == 0,
                2'($urandom % 3),
                ($urandom % 2) ? td + 32'($urandom % 5) - 32'd2 : (32'h1000 | ($urandom % 256)),
                ($urandom % 2) ? td : 32'($urandom),
                ($urandom % 8) == 0);
         for (int i = 0; i < N; i++) t_cnt_clr[i] = ($urandom % 16) == 0;
         rst_l = ($urandom % 64) != 0;
         step();
      end
      rst_l = 1'b1;

      @(posedge clk);
      #2;
      tests++;
      if (sbq.size() != 0) begin
         failed++;
         $display("FAIL drain: %0d results left, expected 0", sbq.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
